load_store_unit: RTL and testbench

- Memory-stage companion to the execute ALU. It takes the effective address computed by the ALU for LOAD/STORE (opcode[6:2] = 00000 / 01000), the func3 width code and the rs2 store data.
- It runs a word-aligned request/ready transaction to data memory, stalls the pipeline while the transaction is outstanding, and returns sign- or zero-extended load data for writeback.
- Misaligned accesses and illegal width codes are flagged instead of issued.

---
 rtl/load_store_unit_if.sv | 20 ++
 rtl/load_store_unit.sv | 161 ++++++++++++++++
 tb/tb_load_store_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - data-memory request/ready bus between the LSU and memory
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store unit with word-aligned request/ready bus
module load_store_unit #(
    parameter int MEM_WAIT_MAX = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [4:0]               opcode,
    input  logic [2:0]               func3,
    input  logic [31:0]              addr,
    input  logic [31:0]              store_data,
    output logic                     stall,
    output logic                     ld_valid,
    output logic [31:0]              ld_data,
    output logic                     fault,
    output logic [1:0]               fault_cause,
    output logic [31:0]              fault_addr,
    load_store_unit_if.master        mem
);
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

    state_t      state, state_nxt;
    logic        is_load, is_store, accept, func3_ok, misaligned, access_ok, timeout;
    logic [7:0]  wait_cnt;
    logic [2:0]  req_func3;
    logic [1:0]  req_off;
    logic [3:0]  strb_nxt;
    logic [31:0] wdata_nxt, lane, ld_ext;

    assign is_load    = (opcode == OP_LOAD);
    assign is_store   = (opcode == OP_STORE);
    assign accept     = (state == IDLE) && in_valid && (is_load || is_store);
    assign misaligned = ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00)) ||
                        ((func3[1:0] == 2'b01) && addr[0]);
    assign access_ok  = func3_ok && !misaligned;
    assign timeout    = (state == REQ) && !mem.mem_ready && (wait_cnt == WAIT_LAST);

    always_comb begin
        func3_ok = 1'b0;
        case (func3)
            3'b000, 3'b001, 3'b010: func3_ok = 1'b1;
            3'b100, 3'b101:         func3_ok = is_load;
            default:                func3_ok = 1'b0;
        endcase
    end

    always_comb begin
        strb_nxt  = 4'b0000;
        wdata_nxt = 32'h0;
        if (is_store) begin
            case (func3[1:0])
                2'b00: begin
                    strb_nxt  = 4'b0001 << addr[1:0];
                    wdata_nxt = {4{store_data[7:0]}};
                end
                2'b01: begin
                    strb_nxt  = 4'b0011 << addr[1:0];
                    wdata_nxt = {2{store_data[15:0]}};
                end
                default: begin
                    strb_nxt  = 4'b1111;
                    wdata_nxt = store_data;
                end
            endcase
        end
    end

    // Shift the addressed byte/half down to bit 0, then extend per the latched width code.
    assign lane = mem.mem_rdata >> {req_off, 3'b000};

    always_comb begin
        ld_ext = lane;
        case (req_func3)
            3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ld_ext = {24'h0, lane[7:0]};
            3'b101:  ld_ext = {16'h0, lane[15:0]};
            default: ld_ext = lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && access_ok) state_nxt = REQ;
            REQ:     if (mem.mem_ready || timeout) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall       = ((state == IDLE) && accept && access_ok) || (state == REQ);
        mem.mem_req = (state == REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_valid      <= 1'b0;
            ld_data       <= 32'h0;
            fault         <= 1'b0;
            fault_cause   <= 2'b00;
            fault_addr    <= 32'h0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'h0;
            mem.mem_wstrb <= 4'b0000;
            mem.mem_wdata <= 32'h0;
            wait_cnt      <= 8'h0;
            req_func3     <= 3'b000;
            req_off       <= 2'b00;
        end else begin
            ld_valid <= 1'b0;
            fault    <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (!func3_ok) begin
                        fault       <= 1'b1;
                        fault_cause <= 2'b10;
                        fault_addr  <= addr;
                    end else if (misaligned) begin
                        fault       <= 1'b1;
                        fault_cause <= 2'b01;
                        fault_addr  <= addr;
                    end else begin
                        mem.mem_addr  <= {addr[31:2], 2'b00};
                        mem.mem_we    <= is_store;
                        mem.mem_wstrb <= strb_nxt;
                        mem.mem_wdata <= wdata_nxt;
                        req_func3     <= func3;
                        req_off       <= addr[1:0];
                        wait_cnt      <= 8'h0;
                    end
                end
                REQ: begin
                    if (mem.mem_ready) begin
                        if (!mem.mem_we) begin
                            ld_valid <= 1'b1;
                            ld_data  <= ld_ext;
                        end
                    end else if (timeout) begin
                        fault       <= 1'b1;
                        fault_cause <= 2'b11;
                        fault_addr  <= {mem.mem_addr[31:2], req_off};
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;
    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;

    logic        clk = 1'b0;
    logic        rst, in_valid, iv_to;
    logic [4:0]  opcode;
    logic [2:0]  func3;
    logic [31:0] addr, store_data;
    logic        stall, ld_valid, fault;
    logic [31:0] ld_data, fault_addr;
    logic [1:0]  fault_cause;
    logic        stall_to, ld_valid_to, fault_to;
    logic [31:0] ld_data_to, fault_addr_to;
    logic [1:0]  fault_cause_to;
    int          vectors = 0;
    int          miscompares = 0;
    int          req_cycles;

    load_store_unit_if bus ();
    load_store_unit_if bus_to ();

    load_store_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .func3(func3),
        .addr(addr), .store_data(store_data), .stall(stall), .ld_valid(ld_valid),
        .ld_data(ld_data), .fault(fault), .fault_cause(fault_cause),
        .fault_addr(fault_addr), .mem(bus)
    );

    load_store_unit #(.MEM_WAIT_MAX(4)) dut_to (
        .clk(clk), .rst(rst), .in_valid(iv_to), .opcode(opcode), .func3(func3),
        .addr(addr), .store_data(store_data), .stall(stall_to), .ld_valid(ld_valid_to),
        .ld_data(ld_data_to), .fault(fault_to), .fault_cause(fault_cause_to),
        .fault_addr(fault_addr_to), .mem(bus_to)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One legal access: accept, (waits) unready REQ cycles, a ready REQ cycle, then RESP.
    task automatic access(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                          input int waits, input logic [31:0] e_maddr, input logic [3:0] e_strb,
                          input logic [31:0] e_wdata, input logic [31:0] e_ld);
        int stalls;
        @(negedge clk);
        in_valid = 1'b1;
        opcode = st ? OP_STORE : OP_LOAD;
        func3 = f3;
        addr = a;
        store_data = sd;
        bus.mem_ready = 1'b0;
        #1 stalls = int'(stall);
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            bus.mem_ready = (i == waits);
            bus.mem_rdata = (i == waits) ? rdata : ~rdata;
            #1 stalls += int'(stall);
            chk({tag, " mem_req"}, 32'(bus.mem_req), 32'd1);
            chk({tag, " mem_addr"}, bus.mem_addr, e_maddr);
            chk({tag, " we/wstrb"}, 32'({bus.mem_we, bus.mem_wstrb}), 32'({st, e_strb}));
            if (st) chk({tag, " mem_wdata"}, bus.mem_wdata, e_wdata);
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        chk({tag, " resp ld_valid"}, 32'(ld_valid), 32'(!st));
        chk({tag, " resp stall/req/fault"}, 32'({stall, bus.mem_req, fault}), 32'd0);
        if (!st) chk({tag, " ld_data"}, ld_data, e_ld);
        chk({tag, " stall cycles"}, 32'(stalls), 32'(waits + 2));
    endtask

    task automatic fault_case(input string tag, input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [1:0] cause);
        @(negedge clk);
        in_valid = 1'b1;
        opcode = st ? OP_STORE : OP_LOAD;
        func3 = f3;
        addr = a;
        #1 chk({tag, " accept stall"}, 32'(stall), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk({tag, " fault"}, 32'(fault), 32'd1);
        chk({tag, " cause"}, 32'(fault_cause), 32'(cause));
        chk({tag, " fault_addr"}, fault_addr, a);
        chk({tag, " no req/stall"}, 32'({bus.mem_req, stall}), 32'd0);
        @(negedge clk);
        #1 chk({tag, " pulse ends"}, 32'({fault, bus.mem_req}), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        iv_to = 1'b0;
        opcode = 5'b0;
        func3 = 3'b0;
        addr = 32'h0;
        store_data = 32'h0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        bus_to.mem_ready = 1'b0;
        bus_to.mem_rdata = 32'h0;

        repeat (2) @(negedge clk);
        #1;
        chk("reset ctl", 32'({stall, ld_valid, fault, fault_cause, bus.mem_req, bus.mem_we, bus.mem_wstrb}), 32'd0);
        chk("reset ld_data", ld_data, 32'h0);
        chk("reset fault_addr", fault_addr, 32'h0);
        chk("reset mem_addr", bus.mem_addr, 32'h0);
        chk("reset mem_wdata", bus.mem_wdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        access("lw", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 32'h100, 4'b0000, 32'h0, 32'hDEADBEEF);
        access("lb", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 32'h100, 4'b0000, 32'h0, 32'hFFFFFF80);
        access("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 32'h100, 4'b0000, 32'h0, 32'h00000080);
        access("lh", 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF0000, 0, 32'h100, 4'b0000, 32'h0, 32'hFFFF80FF);
        access("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF0000, 0, 32'h100, 4'b0000, 32'h0, 32'h000080FF);
        access("lb pos", 1'b0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 0, 32'h100, 4'b0000, 32'h0, 32'h0000007F);
        access("sb", 1'b1, 3'b000, 32'h201, 32'h12345678, 32'h0, 0, 32'h200, 4'b0010, 32'h78787878, 32'h0);
        access("sh", 1'b1, 3'b001, 32'h202, 32'h12345678, 32'h0, 0, 32'h200, 4'b1100, 32'h56785678, 32'h0);
        access("sw", 1'b1, 3'b010, 32'h204, 32'h12345678, 32'h0, 0, 32'h204, 4'b1111, 32'h12345678, 32'h0);
        access("lw wait", 1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 4, 32'h300, 4'b0000, 32'h0, 32'hCAFEF00D);
        access("b2b lw", 1'b0, 3'b010, 32'h400, 32'h0, 32'h11223344, 0, 32'h400, 4'b0000, 32'h0, 32'h11223344);
        access("b2b sw", 1'b1, 3'b010, 32'h404, 32'hAABBCCDD, 32'h0, 0, 32'h404, 4'b1111, 32'hAABBCCDD, 32'h0);

        fault_case("lw misaligned", 1'b0, 3'b010, 32'h102, 2'b01);
        fault_case("lhu misaligned", 1'b0, 3'b101, 32'h103, 2'b01);
        fault_case("sh misaligned", 1'b1, 3'b001, 32'h201, 2'b01);
        fault_case("load f3 011", 1'b0, 3'b011, 32'h100, 2'b10);
        fault_case("load f3 110", 1'b0, 3'b110, 32'h100, 2'b10);
        fault_case("store f3 100", 1'b1, 3'b100, 32'h101, 2'b10);

        @(negedge clk);
        in_valid = 1'b1;
        opcode = 5'b01100;
        func3 = 3'b010;
        addr = 32'h102;
        bus.mem_ready = 1'b1;
        #1 chk("non-mem stall", 32'(stall), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("non-mem quiet", 32'({bus.mem_req, fault, ld_valid}), 32'd0);
        bus.mem_ready = 1'b0;

        @(negedge clk);
        iv_to = 1'b1;
        opcode = OP_LOAD;
        func3 = 3'b010;
        addr = 32'h500;
        bus_to.mem_ready = 1'b0;
        #1 chk("to accept stall", 32'(stall_to), 32'd1);
        req_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (!stall_to) break;
            if (bus_to.mem_req) req_cycles++;
        end
        chk("to req cycles", 32'(req_cycles), 32'd4);
        chk("to fault", 32'(fault_to), 32'd1);
        chk("to cause", 32'(fault_cause_to), 32'd3);
        chk("to fault_addr", fault_addr_to, 32'h500);
        chk("to no ld/req", 32'({ld_valid_to, bus_to.mem_req}), 32'd0);
        @(negedge clk);
        addr = 32'h504;
        #1 chk("to idle reaccept", 32'({fault_to, stall_to}), 32'd1);
        @(negedge clk);
        iv_to = 1'b0;
        bus_to.mem_ready = 1'b1;
        bus_to.mem_rdata = 32'h5555AAAA;
        #1 chk("to2 mem_req", 32'(bus_to.mem_req), 32'd1);
        chk("to2 mem_addr", bus_to.mem_addr, 32'h504);
        @(negedge clk);
        bus_to.mem_ready = 1'b0;
        #1 chk("to2 ld_valid", 32'(ld_valid_to), 32'd1);
        chk("to2 ld_data", ld_data_to, 32'h5555AAAA);

        @(negedge clk);
        in_valid = 1'b1;
        opcode = OP_LOAD;
        func3 = 3'b010;
        addr = 32'h600;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("rst mid req active", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h99999999;
        #1;
        chk("rst mid ctl", 32'({stall, ld_valid, fault, fault_cause, bus.mem_req, bus.mem_we, bus.mem_wstrb}), 32'd0);
        chk("rst mid ld_data", ld_data, 32'h0);
        chk("rst mid fault_addr", fault_addr, 32'h0);
        chk("rst mid mem_addr", bus.mem_addr, 32'h0);
        chk("rst mid mem_wdata", bus.mem_wdata, 32'h0);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1 chk("rst mid abandoned", 32'({ld_valid, fault, bus.mem_req}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
